pipeline_control: RTL and testbench

Central stall/flush sequencer for the five-stage rvga pipeline, sitting beside the forwarding unit. It detects load-use hazards that forwarding cannot cover and holds the pipeline for data-memory handshakes and multi-cycle execute operations. It also turns a taken branch or jump resolved in execute into decode/execute flushes. All stage registers (fetch, decode, execute, memory) take their enable and bubble controls from this block.

---
 rtl/rvga_types_pkg.sv | 32 +++
 rtl/pipeline_control_load_use_detect.sv | 27 ++
 rtl/pipeline_control.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_control.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvga_types_pkg.sv
// Shared rvga pipeline types: register index, stall-sequencer state, per-stage control bundle.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rvga_types;

    // Architectural register index (x0..x31).
    typedef logic [4:0] rvga_reg;

    // Stall sequencer states: free-running, waiting on dmem, waiting on a
    // multi-cycle op, or waiting on dmem while a multi-cycle op is outstanding.
    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        MC_WAIT     = 2'd2,
        MC_MEM_WAIT = 2'd3
    } pipe_ctrl_state_e;

    // Control bundle driven into one stage register.
    typedef struct packed {
        logic stall;
        logic bubble;
        logic flush;
    } stage_ctrl_s;

    localparam stage_ctrl_s STAGE_CTRL_IDLE = '{stall: 1'b0, bubble: 1'b0, flush: 1'b0};

    // True when a read source register is the given destination register.
    function automatic logic reg_hazard(input rvga_reg src, input logic src_v, input rvga_reg dst);
        return src_v && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_control_load_use_detect.sv
// Load-use hazard detect: load in execute writes a register the decode instruction reads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall sequencer directly.
module load_use_detect
    import rvga_types::*;
(
    input  rvga_reg decode_rs1,
    input  logic    decode_rs1_v,
    input  rvga_reg decode_rs2,
    input  logic    decode_rs2_v,
    input  rvga_reg execute_rd,
    input  logic    execute_rd_w_v,
    input  logic    execute_load_v,
    output logic    load_use
);

    logic producer_v;

    // A load only creates a hazard if it really writes a non-x0 register.
    always_comb begin
        producer_v = execute_load_v && execute_rd_w_v && (execute_rd != '0);
        load_use   = producer_v &&
                     (reg_hazard(decode_rs1, decode_rs1_v, execute_rd) ||
                      reg_hazard(decode_rs2, decode_rs2_v, execute_rd));
    end

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the five-stage rvga pipeline (load-use, dmem wait, multi-cycle op, redirect).
// Latency: control outputs combinational from state and inputs; state and perf counters update on clk_i.
// Backpressure: dmem wait stalls every stage, multi-cycle op stalls fetch..execute; optional perf counters with PIPE_CTRL_PERF_EN.
module pipeline_control
    import rvga_types::*;
#(
    parameter int PERF_W = 32
) (
    input  logic    clk_i,
    input  logic    reset_n_i,
    input  rvga_reg decode_rs1_i,
    input  rvga_reg decode_rs2_i,
    input  logic    decode_rs1_v_i,
    input  logic    decode_rs2_v_i,
    input  rvga_reg execute_rd_i,
    input  logic    execute_rd_w_v_i,
    input  logic    execute_load_v_i,
    input  logic    execute_mc_start_i,
    input  logic    execute_mc_done_i,
    input  logic    memory_req_v_i,
    input  logic    memory_ack_i,
    input  logic    redirect_v_i,
    output logic    stall_fetch_o,
    output logic    stall_decode_o,
    output logic    stall_execute_o,
    output logic    stall_memory_o,
    output logic    bubble_execute_o,
    output logic    bubble_memory_o,
    output logic    bubble_writeback_o,
    output logic    flush_decode_o,
    output logic    flush_execute_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles_o,
    output logic [PERF_W-1:0] perf_load_use_o,
    output logic [PERF_W-1:0] perf_flush_o
`endif
);

    pipe_ctrl_state_e state, state_nxt;
    logic             mem_busy;
    logic             mc_pending;
    logic             load_use;

    stage_ctrl_s ctrl_fetch;
    stage_ctrl_s ctrl_decode;
    stage_ctrl_s ctrl_execute;
    stage_ctrl_s ctrl_memory;
    stage_ctrl_s ctrl_writeback;

    load_use_detect u_load_use_detect (
        .decode_rs1     (decode_rs1_i),
        .decode_rs1_v   (decode_rs1_v_i),
        .decode_rs2     (decode_rs2_i),
        .decode_rs2_v   (decode_rs2_v_i),
        .execute_rd     (execute_rd_i),
        .execute_rd_w_v (execute_rd_w_v_i),
        .execute_load_v (execute_load_v_i),
        .load_use       (load_use)
    );

    // The ack cycle itself is not busy, so the memory stall length equals the wait length.
    assign mem_busy = memory_req_v_i && !memory_ack_i;

    // A multi-cycle op holds execute until done is seen. MC_MEM_WAIT is included so that a
    // dmem ack arriving before the op finishes does not let the unfinished op advance.
    assign mc_pending = !execute_mc_done_i &&
                        ((state == MC_WAIT) || (state == MC_MEM_WAIT) ||
                         ((state == RUN) && execute_mc_start_i));

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: dmem wait nests inside a multi-cycle wait, never the other way round.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nxt = MEM_WAIT;
                end else if (execute_mc_start_i) begin
                    state_nxt = MC_WAIT;
                end
            end
            MEM_WAIT: begin
                if (memory_ack_i) begin
                    state_nxt = RUN;
                end
            end
            MC_WAIT: begin
                if (mem_busy) begin
                    state_nxt = MC_MEM_WAIT;
                end else if (execute_mc_done_i) begin
                    state_nxt = RUN;
                end
            end
            MC_MEM_WAIT: begin
                if (memory_ack_i) begin
                    state_nxt = MC_WAIT;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Output decode in priority order: dmem wait, multi-cycle op, redirect, load-use.
    // A redirect under a stall is simply dropped; it persists until the first unstalled cycle.
    always_comb begin
        ctrl_fetch     = STAGE_CTRL_IDLE;
        ctrl_decode    = STAGE_CTRL_IDLE;
        ctrl_execute   = STAGE_CTRL_IDLE;
        ctrl_memory    = STAGE_CTRL_IDLE;
        ctrl_writeback = STAGE_CTRL_IDLE;
        if (mem_busy) begin
            ctrl_fetch.stall      = 1'b1;
            ctrl_decode.stall     = 1'b1;
            ctrl_execute.stall    = 1'b1;
            ctrl_memory.stall     = 1'b1;
            ctrl_writeback.bubble = 1'b1;
        end else if (mc_pending) begin
            ctrl_fetch.stall   = 1'b1;
            ctrl_decode.stall  = 1'b1;
            ctrl_execute.stall = 1'b1;
            ctrl_memory.bubble = 1'b1;
        end else if (redirect_v_i) begin
            ctrl_decode.flush  = 1'b1;
            ctrl_execute.flush = 1'b1;
        end else if (load_use) begin
            ctrl_fetch.stall    = 1'b1;
            ctrl_decode.stall   = 1'b1;
            ctrl_execute.bubble = 1'b1;
        end
    end

    assign stall_fetch_o      = ctrl_fetch.stall;
    assign stall_decode_o     = ctrl_decode.stall;
    assign stall_execute_o    = ctrl_execute.stall;
    assign stall_memory_o     = ctrl_memory.stall;
    assign bubble_execute_o   = ctrl_execute.bubble;
    assign bubble_memory_o    = ctrl_memory.bubble;
    assign bubble_writeback_o = ctrl_writeback.bubble;
    assign flush_decode_o     = ctrl_decode.flush;
    assign flush_execute_o    = ctrl_execute.flush;

    // Bundle fields that no stage register consumes.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_fetch.bubble, ctrl_fetch.flush, ctrl_decode.bubble,
                           ctrl_memory.flush, ctrl_writeback.stall, ctrl_writeback.flush};

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] load_use_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Saturating event counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt    <= '0;
            load_use_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (stall_fetch_o && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_execute_o && (load_use_cnt != '1)) begin
                load_use_cnt <= load_use_cnt + 1'b1;
            end
            if (flush_decode_o && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cycles_o = stall_cnt;
    assign perf_load_use_o     = load_use_cnt;
    assign perf_flush_o        = flush_cnt;
`else
    logic unused_perf_cfg;
    assign unused_perf_cfg = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control.
// Latency: outputs sampled on the falling edge of the cycle the inputs are applied.
// Backpressure: bench plays decode/execute/dmem roles cycle by cycle.
module tb_pipeline_control;
    import rvga_types::*;

    localparam int PERF_W = 32;

    // Packed view of the nine control outputs: {sf, sd, se, sm, be, bm, bw, fd, fe}.
    localparam logic [8:0] O_NONE  = 9'b000_000_000;
    localparam logic [8:0] O_LU    = 9'b110_010_000;
    localparam logic [8:0] O_MEM   = 9'b111_100_100;
    localparam logic [8:0] O_MC    = 9'b111_001_000;
    localparam logic [8:0] O_FLUSH = 9'b000_000_011;

    logic    clk_i = 1'b0;
    logic    reset_n_i;
    rvga_reg decode_rs1_i, decode_rs2_i, execute_rd_i;
    logic    decode_rs1_v_i, decode_rs2_v_i;
    logic    execute_rd_w_v_i, execute_load_v_i;
    logic    execute_mc_start_i, execute_mc_done_i;
    logic    memory_req_v_i, memory_ack_i, redirect_v_i;
    logic    stall_fetch_o, stall_decode_o, stall_execute_o, stall_memory_o;
    logic    bubble_execute_o, bubble_memory_o, bubble_writeback_o;
    logic    flush_decode_o, flush_execute_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_cycles_o, perf_load_use_o, perf_flush_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    pipeline_control #(.PERF_W(PERF_W)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .decode_rs1_i       (decode_rs1_i),
        .decode_rs2_i       (decode_rs2_i),
        .decode_rs1_v_i     (decode_rs1_v_i),
        .decode_rs2_v_i     (decode_rs2_v_i),
        .execute_rd_i       (execute_rd_i),
        .execute_rd_w_v_i   (execute_rd_w_v_i),
        .execute_load_v_i   (execute_load_v_i),
        .execute_mc_start_i (execute_mc_start_i),
        .execute_mc_done_i  (execute_mc_done_i),
        .memory_req_v_i     (memory_req_v_i),
        .memory_ack_i       (memory_ack_i),
        .redirect_v_i       (redirect_v_i),
        .stall_fetch_o      (stall_fetch_o),
        .stall_decode_o     (stall_decode_o),
        .stall_execute_o    (stall_execute_o),
        .stall_memory_o     (stall_memory_o),
        .bubble_execute_o   (bubble_execute_o),
        .bubble_memory_o    (bubble_memory_o),
        .bubble_writeback_o (bubble_writeback_o),
        .flush_decode_o     (flush_decode_o),
        .flush_execute_o    (flush_execute_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles_o(perf_stall_cycles_o),
        .perf_load_use_o    (perf_load_use_o),
        .perf_flush_o       (perf_flush_o)
`endif
    );

    logic [8:0] outs;
    assign outs = {stall_fetch_o, stall_decode_o, stall_execute_o, stall_memory_o,
                   bubble_execute_o, bubble_memory_o, bubble_writeback_o,
                   flush_decode_o, flush_execute_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance to just after the next rising edge.
    task automatic expect_cycle(input string tag, input logic [8:0] exp);
        @(negedge clk_i);
        check(tag, {23'd0, outs}, {23'd0, exp});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        decode_rs1_i       = '0;
        decode_rs2_i       = '0;
        decode_rs1_v_i     = 1'b0;
        decode_rs2_v_i     = 1'b0;
        execute_rd_i       = '0;
        execute_rd_w_v_i   = 1'b0;
        execute_load_v_i   = 1'b0;
        execute_mc_start_i = 1'b0;
        execute_mc_done_i  = 1'b0;
        memory_req_v_i     = 1'b0;
        memory_ack_i       = 1'b0;
        redirect_v_i       = 1'b0;
    endtask

    task automatic set_load(input rvga_reg rd, input logic wv, input rvga_reg rs1, input logic v1,
                            input rvga_reg rs2, input logic v2);
        execute_load_v_i = 1'b1;
        execute_rd_w_v_i = wv;
        execute_rd_i     = rd;
        decode_rs1_i     = rs1;
        decode_rs1_v_i   = v1;
        decode_rs2_i     = rs2;
        decode_rs2_v_i   = v2;
    endtask

    initial begin
        idle_inputs();
        reset_n_i = 1'b0;
        #3;
        check("reset_outputs", {23'd0, outs}, {23'd0, O_NONE});
`ifdef PIPE_CTRL_PERF_EN
        check("reset_perf_stall", perf_stall_cycles_o, 32'd0);
`endif
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Load x5, decode reads rs2=x5: one bubble cycle, then the load has moved on.
        set_load(5'd5, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1);
        expect_cycle("lu_rs2", O_LU);
        idle_inputs();
        expect_cycle("lu_rs2_after", O_NONE);

        set_load(5'd7, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0);
        expect_cycle("lu_rs1", O_LU);
        set_load(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        expect_cycle("lu_rd_x0", O_NONE);
        set_load(5'd5, 1'b1, 5'd3, 1'b1, 5'd5, 1'b0);
        expect_cycle("lu_rs2_not_read", O_NONE);
        set_load(5'd5, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
        expect_cycle("lu_no_write", O_NONE);
        idle_inputs();

        // Fresh counters for the dmem wait.
        reset_n_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        memory_req_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_cycle($sformatf("mem_wait_%0d", i), O_MEM);
        end
        memory_ack_i = 1'b1;
        expect_cycle("mem_ack", O_NONE);
        idle_inputs();
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_mem", perf_stall_cycles_o, 32'd3);
        check("perf_load_use_mem", perf_load_use_o, 32'd0);
`endif
        expect_cycle("mem_back_run", O_NONE);

        // Multi-cycle op: start at t, done at t+4 -> four stall cycles then advance.
        execute_mc_start_i = 1'b1;
        expect_cycle("mc_t0", O_MC);
        execute_mc_start_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            expect_cycle($sformatf("mc_t%0d", i), O_MC);
        end
        execute_mc_done_i = 1'b1;
        expect_cycle("mc_done", O_NONE);
        execute_mc_done_i = 1'b0;
        expect_cycle("mc_back_run", O_NONE);

        // Redirect beats load-use: flush, no stall.
        set_load(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        redirect_v_i = 1'b1;
        expect_cycle("redirect_over_lu", O_FLUSH);
        idle_inputs();

        // Redirect during dmem wait is held back until the ack cycle.
        memory_req_v_i = 1'b1;
        redirect_v_i   = 1'b1;
        expect_cycle("redirect_mem_0", O_MEM);
        expect_cycle("redirect_mem_1", O_MEM);
        memory_ack_i = 1'b1;
        expect_cycle("redirect_on_ack", O_FLUSH);
        idle_inputs();

        // dmem wait inside a multi-cycle op, ack and done together.
        execute_mc_start_i = 1'b1;
        expect_cycle("mcmem_start", O_MC);
        execute_mc_start_i = 1'b0;
        memory_req_v_i     = 1'b1;
        expect_cycle("mcmem_busy", O_MEM);
        memory_ack_i      = 1'b1;
        execute_mc_done_i = 1'b1;
        expect_cycle("mcmem_ack_done", O_NONE);
        memory_req_v_i = 1'b0;
        memory_ack_i   = 1'b0;
        expect_cycle("mcmem_done_held", O_NONE);
        execute_mc_done_i = 1'b0;
        expect_cycle("mcmem_back_run", O_NONE);

        // Reset in the middle of a multi-cycle wait drops the stall at once.
        execute_mc_start_i = 1'b1;
        expect_cycle("mcrst_start", O_MC);
        execute_mc_start_i = 1'b0;
        @(negedge clk_i);
        check("mcrst_pre", {23'd0, outs}, {23'd0, O_MC});
        reset_n_i = 1'b0;
        #1;
        check("mcrst_in_reset", {23'd0, outs}, {23'd0, O_NONE});
`ifdef PIPE_CTRL_PERF_EN
        check("mcrst_perf_stall", perf_stall_cycles_o, 32'd0);
        check("mcrst_perf_flush", perf_flush_o, 32'd0);
`endif
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        expect_cycle("mcrst_after", O_NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
